// File: rtl/traceback_walker.sv
// traceback_walker: walks a direction matrix from (len_a,len_b) back to (0,0), emitting one arrow per 3 cycles.
// Ports: clk/rst (async, active-high); start + len_a/len_b launch a walk;
//   addr_i/addr_j -> dir_symbol and addr_a/addr_b -> seqA_data/seqB_data are 1-cycle-latency reads;
//   en_traceB strobes symbol/SeqA_i_t/SeqB_j_t; step_cnt counts steps; busy/done/err report status.
// Optional: define TB_WATCHDOG_EN to abort with err once step_cnt exceeds len_a+len_b.
module traceback_walker #(
  parameter int N  = 128,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] len_a,
  input  logic [IW-1:0] len_b,
  output logic [IW-1:0] addr_i,
  output logic [IW-1:0] addr_j,
  input  logic [2:0]    dir_symbol,
  output logic [IW-1:0] addr_a,
  output logic [IW-1:0] addr_b,
  input  logic [2:0]    seqA_data,
  input  logic [2:0]    seqB_data,
  output logic          en_traceB,
  output logic [2:0]    symbol,
  output logic [2:0]    SeqA_i_t,
  output logic [2:0]    SeqB_j_t,
  output logic [IW:0]   step_cnt,
  output logic          busy,
  output logic          done,
  output logic          err
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;
  state_t r_state;
  logic [IW-1:0] r_i, r_j;
  logic [IW-1:0] w_la, w_lb, w_ni, w_nj;
  logic [2:0] w_sym;
  logic w_ok;
`ifdef TB_WATCHDOG_EN
  logic [IW:0] r_lim;
`endif
  // out-of-range lengths are clamped to N so the walk stays bounded
  assign w_la = (32'(len_a) > N) ? IW'(N) : len_a;
  assign w_lb = (32'(len_b) > N) ? IW'(N) : len_b;
  // on a matrix edge the only legal move is along that edge
  assign w_sym = (r_i == '0 && r_j != '0) ? 3'b100 :
                 (r_j == '0 && r_i != '0) ? 3'b010 : dir_symbol;
  assign w_ok = w_sym == 3'b001 || w_sym == 3'b100 || w_sym == 3'b010;
  assign w_ni = w_sym[2] ? r_i : r_i - 1'b1;
  assign w_nj = w_sym[1] ? r_j : r_j - 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_i       <= '0;
      r_j       <= '0;
`ifdef TB_WATCHDOG_EN
      r_lim     <= '0;
`endif
      addr_i    <= '0;
      addr_j    <= '0;
      addr_a    <= '0;
      addr_b    <= '0;
      symbol    <= '0;
      SeqA_i_t  <= '0;
      SeqB_j_t  <= '0;
      step_cnt  <= '0;
      en_traceB <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      en_traceB <= 1'b0;
      done      <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_i      <= w_la;
          r_j      <= w_lb;
`ifdef TB_WATCHDOG_EN
          r_lim    <= {1'b0, w_la} + {1'b0, w_lb};
`endif
          step_cnt <= '0;
          err      <= 1'b0;
          busy     <= 1'b1;
          r_state  <= FETCH;
        end
        FETCH:
`ifdef TB_WATCHDOG_EN
          if (step_cnt > r_lim) begin
            err     <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end else
`endif
          begin
            addr_i  <= r_i;
            addr_j  <= r_j;
            // clamp keeps the sequence address in range on the i==0 / j==0 edges
            addr_a  <= (r_i == '0) ? '0 : r_i - 1'b1;
            addr_b  <= (r_j == '0) ? '0 : r_j - 1'b1;
            r_state <= WAIT;
          end
        WAIT: r_state <= EMIT;
        EMIT: if (!w_ok) begin
          err     <= 1'b1;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= DONE;
        end else begin
          symbol    <= w_sym;
          SeqA_i_t  <= seqA_data;
          SeqB_j_t  <= seqB_data;
          en_traceB <= 1'b1;
          step_cnt  <= step_cnt + 1'b1;
          r_i       <= w_ni;
          r_j       <= w_nj;
          if (w_ni == '0 && w_nj == '0) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end else begin
            r_state <= FETCH;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/traceback_walker.md
TRACEBACK_WALKER -- requirements
Module: traceback_walker

Interface
REQ-001 Parameter N, default 128: maximum sequence length.
REQ-002 Parameter IW, default 8: index width; SHALL hold 0..N.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that launches a traceback.
REQ-006 len_a, len_b  input  IW each  sequence lengths, sampled on start, each 1..N.
REQ-007 addr_i, addr_j  output  IW each  direction-matrix cell address (row i, column j).
REQ-008 dir_symbol  input  3  matrix read data, valid 1 cycle after the address.
REQ-009 addr_a, addr_b  output  IW each  sequence memory addresses (i-1, j-1).
REQ-010 seqA_data, seqB_data  input  3 each  sequence read data, valid 1 cycle after the address.
REQ-011 en_traceB  output  1  step-valid strobe to the scoring stage.
REQ-012 symbol  output  3  arrow for this step: 001 diagonal, 100 left, 010 up.
REQ-013 SeqA_i_t, SeqB_j_t  output  3 each  characters for this step.
REQ-014 step_cnt  output  IW+1  steps emitted since start.
REQ-015 busy, done, err  output  1 each  status.

Function
REQ-016 FSM states: IDLE, FETCH, WAIT, EMIT, DONE.
REQ-017 IDLE: on start, load i=len_a, j=len_b, clear step_cnt, err and done, then go to FETCH.
REQ-018 FETCH: drive addr_i=i, addr_j=j, addr_a=i-1, addr_b=j-1, then go to WAIT.
REQ-019 WAIT: memory latency cycle; go to EMIT.
REQ-020 EMIT: register symbol, SeqA_i_t and SeqB_j_t; assert en_traceB for exactly this one cycle; increment step_cnt.
REQ-021 Index update in EMIT:
  - 001: i-1 and j-1.
  - 100: j-1.
  - 010: i-1.
REQ-022 Boundary rule: i==0 with j>0 forces symbol 100 regardless of dir_symbol; j==0 with i>0 forces symbol 010.
REQ-023 In EMIT, the updated i==0 and j==0 go to DONE; otherwise go to FETCH.
REQ-024 Any dir_symbol outside {001,100,010}, when not forced by REQ-022: set err, emit nothing, go to DONE.
REQ-025 DONE: pulse done for one cycle, then go to IDLE.
REQ-026 busy SHALL be high in FETCH, WAIT and EMIT.
REQ-027 start while busy or in DONE SHALL be ignored.
REQ-028 Throughput: one step per 3 cycles. The first en_traceB comes 3 cycles after start is sampled.
REQ-029 en_traceB SHALL be low in every state other than EMIT; symbol and character outputs hold their last value.
REQ-030 Step count SHALL lie between max(len_a,len_b) and len_a+len_b inclusive.
REQ-031 Index arithmetic is unsigned. Decrement below 0 SHALL never occur; the REQ-022 forcing guarantees this.

Reset
REQ-032 On rst: FSM goes to IDLE; i, j and step_cnt go to 0; all addresses go to 0; symbol, SeqA_i_t and SeqB_j_t go to 0; en_traceB, busy, done and err go to 0.
REQ-033 rst asserted mid-traceback SHALL abort immediately with no further en_traceB. A new start is accepted on the first clock after rst deasserts.

Configuration
REQ-034 Macro TB_WATCHDOG_EN: when defined, step_cnt exceeding len_a+len_b sets err and forces DONE on the next cycle.
REQ-035 Without TB_WATCHDOG_EN: no step limit check exists, and err is set only by REQ-024.

Verification
REQ-036 len_a=len_b=4, all cells 001 -> 4 en_traceB pulses, 3 cycles apart, symbol 001 each; step_cnt=4; done pulse; err=0.
REQ-037 len_a=3, len_b=1, matrix at (3,1)=001 -> steps 001, 010 (forced), 010 (forced); addr_a sequence 2,1,0; step_cnt=3.
REQ-038 len_a=2, len_b=2, dir_symbol at (2,2)=011 -> no en_traceB, err=1, done pulses once.
REQ-039 rst asserted after the 2nd en_traceB of a 4-step walk -> all outputs 0 immediately. A fresh start then yields 4 steps.
REQ-040 start pulsed again during busy -> ignored; step_cnt and i/j progression identical to a single-start run.
REQ-041 With TB_WATCHDOG_EN, a model memory that always returns 100 but keeps j fixed -> err=1 once step_cnt=len_a+len_b+1.
